alu_operand_entry: RTL and testbench



---
 rtl/alu_operand_entry_if.sv | 12 +
 rtl/alu_operand_entry.sv | 103 ++++++++++
 tb/tb_alu_operand_entry.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_operand_entry_if.sv
// alu_operand_entry_if: latched operand set presented by the entry front end to the ALU.
interface alu_operand_entry_if;
    logic [31:0] porta;
    logic [31:0] portb;
    logic [3:0]  aluop;
    logic        op_valid;
    logic        op_strobe;
    logic [1:0]  stage;

    modport master (output porta, portb, aluop, op_valid, op_strobe, stage);
    modport slave  (input  porta, portb, aluop, op_valid, op_strobe, stage);
endinterface

// File: rtl/alu_operand_entry.sv
// alu_operand_entry: debounced enter/cancel keys step A -> B -> opcode -> SHOW from the switches.
// ALU_ENTRY_SIGN_EXT_EN selects sign extension of SW[16] into the upper operand half.
module alu_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [3:0]           KEY,
    input  logic [16:0]          SW,
    alu_operand_entry_if.master  bus
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_OP, SHOW} state_t;

    state_t        state, state_nx;
    logic [3:0]    key_s1, key_s2, key_db, key_db_d, press;
    logic [16:0]   sw_s1, sw_s2;
    logic [CW-1:0] cnt [4];
    logic [31:0]   porta, portb, ext;
    logic [3:0]    aluop;
    logic          op_strobe, enter, cancel, unused;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    // press is registered off the delayed level so it lands one cycle after the debounced fall
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < 4; k++) cnt[k] <= '0;
            key_db   <= 4'hF;
            key_db_d <= 4'hF;
            press    <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (key_s2[k] == key_db[k]) cnt[k] <= '0;
                else if (cnt[k] == CNT_MAX) begin
                    cnt[k]    <= '0;
                    key_db[k] <= key_s2[k];
                end else cnt[k] <= cnt[k] + 1'b1;
            end
            key_db_d <= key_db;
            press    <= key_db_d & ~key_db;
        end
    end

    assign enter  = press[0];
    assign cancel = press[1];

`ifdef ALU_ENTRY_SIGN_EXT_EN
    assign ext    = {{16{sw_s2[16]}}, sw_s2[15:0]};
    assign unused = ^press[3:2];
`else
    assign ext    = {16'h0000, sw_s2[15:0]};
    assign unused = ^{press[3:2], sw_s2[16]};
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= LOAD_A;
        else       state <= state_nx;
    end

    // enter advances with natural wrap from SHOW back to LOAD_A; cancel overrides
    always_comb begin
        state_nx = cancel ? LOAD_A : enter ? state_t'(state + 2'd1) : state;
    end

    always_comb begin
        bus.op_valid = state == SHOW;
        bus.stage    = state;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            porta     <= '0;
            portb     <= '0;
            aluop     <= '0;
            op_strobe <= 1'b0;
        end else begin
            op_strobe <= enter && !cancel && state == LOAD_OP;
            porta     <= cancel ? '0 : enter && state == LOAD_A  ? ext         : porta;
            portb     <= cancel ? '0 : enter && state == LOAD_B  ? ext         : portb;
            aluop     <= cancel ? '0 : enter && state == LOAD_OP ? sw_s2[3:0]  : aluop;
        end
    end

    assign bus.porta     = porta;
    assign bus.portb     = portb;
    assign bus.aluop     = aluop;
    assign bus.op_strobe = op_strobe;
endmodule

// File: tb/tb_alu_operand_entry.sv
// tb_alu_operand_entry: directed plus randomized key/switch sequences against a behavioural entry model.
module tb_alu_operand_entry;
    logic        CLK  = 1'b0;
    logic        nRST = 1'b0;
    logic [3:0]  KEY  = 4'hF;
    logic [16:0] SW   = '0;

    alu_operand_entry_if bus();

    alu_operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .KEY  (KEY),
        .SW   (SW),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int          nvec = 0;
    int          nerr = 0;
    int          m_state = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [3:0]  m_op = '0;
    logic        m_strobe = 1'b0;

    function automatic logic [31:0] extend(input logic [16:0] sw);
        logic [31:0] v;
        v = {15'd0, sw};
`ifdef ALU_ENTRY_SIGN_EXT_EN
        return v >= 32'h10000 ? v + 32'hFFFE0000 : v;
`else
        return v % 32'h10000;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_stage"}, 32'(bus.stage), 32'(m_state));
        check({tag, "_porta"}, bus.porta, m_a);
        check({tag, "_portb"}, bus.portb, m_b);
        check({tag, "_aluop"}, 32'(bus.aluop), 32'(m_op));
        check({tag, "_valid"}, 32'(bus.op_valid), 32'(m_state == 3));
    endtask

    task automatic model_reset();
        m_state = 0;
        m_a = '0;
        m_b = '0;
        m_op = '0;
        m_strobe = 1'b0;
    endtask

    task automatic apply(input logic [1:0] mask, input logic [16:0] sw);
        m_strobe = 1'b0;
        if (mask[1]) model_reset();
        else if (mask[0]) begin
            case (m_state)
                0: m_a = extend(sw);
                1: m_b = extend(sw);
                2: begin m_op = 4'(sw % 16); m_strobe = 1'b1; end
                default: ;
            endcase
            m_state = (m_state + 1) % 4;
        end
    endtask

    // the next posedge is the first to sample the key low; the event must land exactly 7 edges later
    task automatic expect_event(input string tag, input logic [1:0] mask, input logic [16:0] sw);
        repeat (7) @(posedge CLK);
        @(negedge CLK);
        check({tag, "_early"}, 32'(bus.stage), 32'(m_state));
        @(posedge CLK);
        @(negedge CLK);
        apply(mask, sw);
        check_all(tag);
        check({tag, "_strobe"}, 32'(bus.op_strobe), 32'(m_strobe));
        @(posedge CLK);
        @(negedge CLK);
        check({tag, "_strobe_end"}, 32'(bus.op_strobe), 32'd0);
    endtask

    task automatic press(input string tag, input logic [1:0] mask, input logic [16:0] sw, input int extra);
        @(negedge CLK);
        SW  = sw;
        KEY = ~{2'b00, mask};
        expect_event(tag, mask, sw);
        repeat (extra) @(negedge CLK);
        KEY = 4'hF;
        repeat (12) @(negedge CLK);
        check_all({tag, "_rel"});
        check({tag, "_rel_strobe"}, 32'(bus.op_strobe), 32'd0);
    endtask

    initial begin
        logic [16:0] sw;
        logic [1:0]  mask;
        int          r;
        model_reset();
        repeat (4) begin
            @(negedge CLK);
            KEY = 4'($urandom);
            SW  = 17'($urandom);
        end
        check_all("reset");
        check("reset_strobe", 32'(bus.op_strobe), 32'd0);
        KEY = 4'hF;
        @(negedge CLK);
        nRST = 1'b1;
        repeat (10) @(negedge CLK);
        check_all("idle");

        press("seq_a",  2'b01, 17'h18000, 0);
        press("seq_b",  2'b01, 17'h00005, 0);
        press("seq_op", 2'b01, 17'h00003, 0);
        press("wrap",   2'b01, 17'($urandom), 0);

        @(negedge CLK);
        KEY = 4'hE;
        repeat (3) @(negedge CLK);
        KEY = 4'hF;
        repeat (15) @(negedge CLK);
        check_all("glitch");
        check("glitch_strobe", 32'(bus.op_strobe), 32'd0);

        press("hold",   2'b01, 17'($urandom), 12);
        press("to_op",  2'b01, 17'($urandom), 0);
        press("cancel", 2'b11, 17'($urandom), 0);

        press("pre_rst", 2'b01, 17'($urandom), 0);
        @(negedge CLK);
        sw  = 17'($urandom);
        SW  = sw;
        KEY = 4'hE;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        expect_event("post_rst", 2'b01, sw);
        KEY = 4'hF;
        repeat (12) @(negedge CLK);

        for (int i = 0; i < 16; i++) begin
            r    = int'($urandom_range(0, 4));
            mask = r < 3 ? 2'b01 : r == 3 ? 2'b10 : 2'b11;
            press("rand", mask, 17'($urandom_range(0, 17'h1FFFF)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
